// File: rtl/adder_bist_pkg.sv
// Shared types and default constants for the adder BIST response-compaction path.
// The MISR defaults describe x^17 + x^14 + 1 for a 17-bit (16-bit sum + carry) signature.
package adder_bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 17;
    localparam int unsigned DEF_CNT_W = 16;

    // Bit i set means a feedback tap at x^i; x^17 itself is implied by the shift-out.
    localparam logic [DEF_WIDTH-1:0] DEF_POLY = 17'h04001;
    localparam logic [DEF_WIDTH-1:0] DEF_SEED = 17'h00000;

endpackage

// File: rtl/misr_core.sv
// Galois multiple-input signature register: shift with feedback, then fold in the new word.
// Holds its value unless told to load the seed or absorb a sample.
module misr_core #(
    parameter int unsigned       WIDTH = 17,
    parameter logic [WIDTH-1:0]  POLY  = 17'h04001
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    logic [WIDTH-1:0] sig_next;

    // The MSB shifted out selects whether the feedback mask is applied.
    always_comb begin
        sig_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sig <= seed;
        end else if (shift_en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/adder_resp_misr.sv
// Compacts a programmed number of adder sums into a MISR signature and grades it
// against a golden value latched at start.
module adder_resp_misr
    import adder_bist_pkg::*;
#(
    parameter int unsigned       WIDTH = DEF_WIDTH,
    parameter int unsigned       CNT_W = DEF_CNT_W,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0]  SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [WIDTH-1:0] expected,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] expected_q;
    logic [WIDTH-1:0] next_sig;
    logic             accept_start;
    logic             absorb;
    logic             misr_load;

    assign accept_start = start && (state != RUN);
    assign absorb       = (state == RUN) && in_valid;

    // Reset reuses the seed-load path so the signature register needs no reset of its own.
    assign misr_load = reset || accept_start;

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_misr (
        .clk      (clk),
        .load     (misr_load),
        .seed     (SEED),
        .shift_en (absorb),
        .din      (din),
        .sig      (signature)
    );

    // Look-ahead of the MISR result so pass can be registered on the same edge as the last sample.
    always_comb begin
        next_sig = {signature[WIDTH-2:0], 1'b0} ^ (signature[WIDTH-1] ? POLY : '0) ^ din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            remaining  <= '0;
            expected_q <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        remaining  <= num_samples;
                        expected_q <= expected;
                        if (num_samples == '0) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (SEED == expected);
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            pass  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (in_valid && (remaining != '0)) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (next_sig == expected_q);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
